// File: rtl/ft245_dev_emu.sv
// Device-side FT245 asynchronous FIFO responder: answers host rd_n/wr_n strobes
// from two local byte FIFOs (RX filled by the fabric, TX drained by the fabric).

module ft245_byte_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk_i,
  input  logic                  sync_rst,
  input  logic                  push,
  input  logic [7:0]            push_data,
  input  logic                  pop,
  output logic [DEPTH_LOG2:0]   level,
  output logic [7:0]            head,
  output logic                  not_full
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   LEVEL_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_reg, wr_ptr_next;
  logic [DEPTH_LOG2-1:0] rd_ptr_reg, rd_ptr_next;
  logic [DEPTH_LOG2:0]   level_reg, level_next;
  logic [7:0]            head_reg, head_next;
  logic                  not_full_reg;
  logic                  push_ok, pop_ok;

  assign push_ok = push && (level_reg != FULL_LEVEL);
  assign pop_ok  = pop && (level_reg != '0);

  always_comb begin
    wr_ptr_next = push_ok ? wr_ptr_reg + PTR_ONE : wr_ptr_reg;
    rd_ptr_next = pop_ok ? rd_ptr_reg + PTR_ONE : rd_ptr_reg;
    level_next  = level_reg;
    if (push_ok && !pop_ok) begin
      level_next = level_reg + LEVEL_ONE;
    end else if (pop_ok && !push_ok) begin
      level_next = level_reg - LEVEL_ONE;
    end
    // The slot written this cycle is not in mem yet, so forward it to the head.
    if (level_next == '0) begin
      head_next = 8'h00;
    end else if (push_ok && (rd_ptr_next == wr_ptr_reg)) begin
      head_next = push_data;
    end else begin
      head_next = mem[rd_ptr_next];
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk_i) begin
    if (sync_rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      head_reg     <= 8'h00;
      not_full_reg <= 1'b0;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      level_reg    <= level_next;
      head_reg     <= head_next;
      not_full_reg <= (level_next != FULL_LEVEL);
    end
  end

  assign level    = level_reg;
  assign head     = head_reg;
  assign not_full = not_full_reg;
endmodule

module ft245_dev_emu #(
  parameter int DEPTH_LOG2 = 4,
  parameter int PRECHARGE  = 2
) (
  input  logic                  clk_i,
  input  logic                  sync_rst,
  input  logic                  rd_n,
  input  logic                  wr_n,
  input  logic [7:0]            data_in,
  output logic                  rxf_n,
  output logic                  txe_n,
  output logic [7:0]            data_out,
  output logic                  data_oe,
  input  logic                  rx_push_valid,
  input  logic [7:0]            rx_push_data,
  output logic                  rx_push_ready,
  output logic                  tx_pop_valid,
  output logic [7:0]            tx_pop_data,
  input  logic                  tx_pop_ready,
  output logic [DEPTH_LOG2:0]   rx_level,
  output logic [DEPTH_LOG2:0]   tx_level,
  output logic                  rd_err,
  output logic                  wr_err
);
  localparam logic [DEPTH_LOG2:0] FULL_LEVEL   = (DEPTH_LOG2 + 1)'(1 << DEPTH_LOG2);
  localparam logic [3:0]          PRECHG_LAST  = 4'(PRECHARGE - 1);

  typedef enum logic [1:0] {R_EMPTY, R_READY, R_STROBE, R_PRECHG} rx_state_t;
  typedef enum logic [1:0] {T_FULL, T_READY, T_STROBE, T_PRECHG} tx_state_t;

  // Bit 0 carries rd_n, bit 1 carries wr_n through the synchroniser chain.
  logic [1:0] meta_reg, sync_reg, dly_reg;
  logic       rd_fall, rd_rise, wr_fall, wr_rise;

  rx_state_t  rx_state_reg, rx_state_next;
  tx_state_t  tx_state_reg, tx_state_next;
  logic [3:0] rx_cnt_reg, rx_cnt_next;
  logic [3:0] tx_cnt_reg, tx_cnt_next;
  logic       rx_host_pop, tx_host_push;
  logic       rd_err_set, wr_err_set;
  logic       rd_err_reg, wr_err_reg;
  logic       rx_not_full;
  logic [7:0] rx_head, tx_head;

  always_ff @(posedge clk_i) begin
    if (sync_rst) begin
      meta_reg <= 2'b11;
      sync_reg <= 2'b11;
      dly_reg  <= 2'b11;
    end else begin
      meta_reg <= {wr_n, rd_n};
      sync_reg <= meta_reg;
      dly_reg  <= sync_reg;
    end
  end

  assign rd_fall = dly_reg[0] & ~sync_reg[0];
  assign rd_rise = ~dly_reg[0] & sync_reg[0];
  assign wr_fall = dly_reg[1] & ~sync_reg[1];
  assign wr_rise = ~dly_reg[1] & sync_reg[1];

  // RX side: host reads bytes the fabric pushed.
  always_ff @(posedge clk_i) begin
    if (sync_rst) begin
      rx_state_reg <= R_EMPTY;
      rx_cnt_reg   <= 4'd0;
    end else begin
      rx_state_reg <= rx_state_next;
      rx_cnt_reg   <= rx_cnt_next;
    end
  end

  always_comb begin
    rx_state_next = rx_state_reg;
    rx_cnt_next   = rx_cnt_reg;
    case (rx_state_reg)
      R_EMPTY:  if (rx_level != '0) rx_state_next = R_READY;
      R_READY:  if (rd_fall) rx_state_next = R_STROBE;
      R_STROBE: begin
        if (rd_rise) begin
          rx_state_next = R_PRECHG;
          rx_cnt_next   = 4'd0;
        end
      end
      R_PRECHG: begin
        if (rx_cnt_reg == PRECHG_LAST) begin
          rx_state_next = (rx_level != '0) ? R_READY : R_EMPTY;
        end else begin
          rx_cnt_next = rx_cnt_reg + 4'd1;
        end
      end
      default:  rx_state_next = R_EMPTY;
    endcase
  end

  always_comb begin
    rxf_n       = (rx_state_reg != R_READY);
    rx_host_pop = (rx_state_reg == R_STROBE) && rd_rise;
    rd_err_set  = rd_fall && (rx_state_reg != R_READY);
  end

  // TX side: host writes bytes the fabric drains.
  always_ff @(posedge clk_i) begin
    if (sync_rst) begin
      tx_state_reg <= T_FULL;
      tx_cnt_reg   <= 4'd0;
    end else begin
      tx_state_reg <= tx_state_next;
      tx_cnt_reg   <= tx_cnt_next;
    end
  end

  always_comb begin
    tx_state_next = tx_state_reg;
    tx_cnt_next   = tx_cnt_reg;
    case (tx_state_reg)
      T_FULL:   if (tx_level != FULL_LEVEL) tx_state_next = T_READY;
      T_READY:  if (wr_fall) tx_state_next = T_STROBE;
      T_STROBE: begin
        if (wr_rise) begin
          tx_state_next = T_PRECHG;
          tx_cnt_next   = 4'd0;
        end
      end
      T_PRECHG: begin
        if (tx_cnt_reg == PRECHG_LAST) begin
          tx_state_next = (tx_level == FULL_LEVEL) ? T_FULL : T_READY;
        end else begin
          tx_cnt_next = tx_cnt_reg + 4'd1;
        end
      end
      default:  tx_state_next = T_FULL;
    endcase
  end

  always_comb begin
    txe_n        = (tx_state_reg != T_READY);
    tx_host_push = (tx_state_reg == T_READY) && wr_fall;
    wr_err_set   = wr_fall && (tx_state_reg != T_READY);
  end

  always_ff @(posedge clk_i) begin
    if (sync_rst) begin
      rd_err_reg <= 1'b0;
      wr_err_reg <= 1'b0;
    end else begin
      if (rd_err_set) rd_err_reg <= 1'b1;
      if (wr_err_set) wr_err_reg <= 1'b1;
    end
  end

  ft245_byte_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
    .clk_i     (clk_i),
    .sync_rst  (sync_rst),
    .push      (rx_push_valid & rx_not_full),
    .push_data (rx_push_data),
    .pop       (rx_host_pop),
    .level     (rx_level),
    .head      (rx_head),
    .not_full  (rx_not_full)
  );

  // data_in is only sampled in the wr_s falling-edge cycle, long after it settled.
  ft245_byte_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
    .clk_i     (clk_i),
    .sync_rst  (sync_rst),
    .push      (tx_host_push),
    .push_data (data_in),
    .pop       (tx_pop_valid & tx_pop_ready),
    .level     (tx_level),
    .head      (tx_head),
    .not_full  ()
  );

  assign data_out      = rx_head;
  assign data_oe       = ~rd_n;
  assign rx_push_ready = rx_not_full;
  assign tx_pop_valid  = (tx_level != '0);
  assign tx_pop_data   = tx_head;
  assign rd_err        = rd_err_reg;
  assign wr_err        = wr_err_reg;
endmodule

// File: tb/tb_ft245_dev_emu.sv
// Directed bench for ft245_dev_emu: a per-cycle vector table for the first read
// and write transfers, then hand sequences for fill/drain, errors and reset.

module tb_ft245_dev_emu;
  localparam int DEPTH_LOG2 = 4;
  localparam int PRECHARGE  = 2;
  localparam int NV         = 21;

  logic       clk_i = 1'b0;
  logic       sync_rst;
  logic       rd_n, wr_n;
  logic [7:0] data_in;
  logic       rxf_n, txe_n, data_oe;
  logic [7:0] data_out;
  logic       rx_push_valid, rx_push_ready;
  logic [7:0] rx_push_data;
  logic       tx_pop_valid, tx_pop_ready;
  logic [7:0] tx_pop_data;
  logic [DEPTH_LOG2:0] rx_level, tx_level;
  logic       rd_err, wr_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  ft245_dev_emu #(.DEPTH_LOG2(DEPTH_LOG2), .PRECHARGE(PRECHARGE)) dut (
    .clk_i         (clk_i),
    .sync_rst      (sync_rst),
    .rd_n          (rd_n),
    .wr_n          (wr_n),
    .data_in       (data_in),
    .rxf_n         (rxf_n),
    .txe_n         (txe_n),
    .data_out      (data_out),
    .data_oe       (data_oe),
    .rx_push_valid (rx_push_valid),
    .rx_push_data  (rx_push_data),
    .rx_push_ready (rx_push_ready),
    .tx_pop_valid  (tx_pop_valid),
    .tx_pop_data   (tx_pop_data),
    .tx_pop_ready  (tx_pop_ready),
    .rx_level      (rx_level),
    .tx_level      (tx_level),
    .rd_err        (rd_err),
    .wr_err        (wr_err)
  );

  typedef struct {
    logic       rd_n, wr_n;
    logic [7:0] din;
    logic       pv;
    logic [7:0] pd;
    logic       pr;
    logic       rxf_n, txe_n;
    logic [7:0] dout;
    logic       oe;
    logic [4:0] rxl, txl;
    logic       prdy, tval;
    logic [7:0] tdata;
  } vec_t;

  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_rxf_low(input string name);
    int k = 0;
    while (rxf_n !== 1'b0 && k < 40) begin
      @(negedge clk_i);
      k++;
    end
    check(name, {31'd0, rxf_n}, 32'd0);
  endtask

  task automatic wait_txe_low(input string name);
    int k = 0;
    while (txe_n !== 1'b0 && k < 40) begin
      @(negedge clk_i);
      k++;
    end
    check(name, {31'd0, txe_n}, 32'd0);
  endtask

  task automatic host_read(input logic [7:0] exp);
    wait_rxf_low("read_rxf_timeout");
    check("read_data", {24'd0, data_out}, {24'd0, exp});
    $display("host read: data_out=0x%02h expected 0x%02h rx_level=%0d", data_out, exp, rx_level);
    rd_n = 1'b0;
    repeat (3) @(negedge clk_i);
    rd_n = 1'b1;
  endtask

  task automatic host_write(input logic [7:0] b, input bit wait_ready);
    if (wait_ready) wait_txe_low("write_txe_timeout");
    data_in = b;
    wr_n = 1'b0;
    repeat (4) @(negedge clk_i);
    wr_n = 1'b1;
    $display("host write: data_in=0x%02h tx_level=%0d", b, tx_level);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // rd wr din  pv pd    pr | rxf txe dout oe rxl txl prdy tval tdata
    vecs[0]  = '{1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 8'h00};
    vecs[1]  = '{1'b1, 1'b1, 8'h00, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 5'd1, 5'd0, 1'b1, 1'b0, 8'h00};
    vecs[2]  = '{1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 5'd1, 5'd0, 1'b1, 1'b0, 8'h00};
    vecs[3]  = '{1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 8'h00};
    vecs[4]  = '{1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 8'h00};
    vecs[5]  = '{1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 8'h00};
    vecs[6]  = '{1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 5'd1, 5'd0, 1'b1, 1'b0, 8'h00};
    vecs[7]  = '{1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 5'd1, 5'd0, 1'b1, 1'b0, 8'h00};
    vecs[8]  = '{1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 8'h00};
    vecs[9]  = '{1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 8'h00};
    vecs[10] = '{1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 8'h00};
    vecs[11] = '{1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 8'h00};
    vecs[12] = '{1'b1, 1'b0, 8'h3C, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 8'h00};
    vecs[13] = '{1'b1, 1'b0, 8'h3C, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 8'h00};
    vecs[14] = '{1'b1, 1'b0, 8'h3C, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 5'd0, 5'd1, 1'b1, 1'b1, 8'h3C};
    vecs[15] = '{1'b1, 1'b0, 8'h3C, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 5'd0, 5'd1, 1'b1, 1'b1, 8'h3C};
    vecs[16] = '{1'b1, 1'b1, 8'h3C, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 5'd0, 5'd1, 1'b1, 1'b1, 8'h3C};
    vecs[17] = '{1'b1, 1'b1, 8'h3C, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 5'd0, 5'd1, 1'b1, 1'b1, 8'h3C};
    vecs[18] = '{1'b1, 1'b1, 8'h3C, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 5'd0, 5'd1, 1'b1, 1'b1, 8'h3C};
    vecs[19] = '{1'b1, 1'b1, 8'h3C, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 5'd0, 5'd1, 1'b1, 1'b1, 8'h3C};
    vecs[20] = '{1'b1, 1'b1, 8'h3C, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 5'd0, 5'd1, 1'b1, 1'b1, 8'h3C};

    sync_rst = 1'b1;
    rd_n = 1'b1;
    wr_n = 1'b1;
    data_in = 8'h00;
    rx_push_valid = 1'b0;
    rx_push_data = 8'h00;
    tx_pop_ready = 1'b0;
    repeat (3) @(negedge clk_i);
    check("rst_rxf_n", {31'd0, rxf_n}, 32'd1);
    check("rst_txe_n", {31'd0, txe_n}, 32'd1);
    check("rst_data_out", {24'd0, data_out}, 32'd0);
    check("rst_push_ready", {31'd0, rx_push_ready}, 32'd0);
    check("rst_pop_valid", {31'd0, tx_pop_valid}, 32'd0);
    check("rst_rx_level", {27'd0, rx_level}, 32'd0);
    check("rst_tx_level", {27'd0, tx_level}, 32'd0);
    check("rst_rd_err", {31'd0, rd_err}, 32'd0);
    check("rst_wr_err", {31'd0, wr_err}, 32'd0);
    $display("reset: rxf_n=%0b txe_n=%0b levels=%0d/%0d", rxf_n, txe_n, rx_level, tx_level);
    sync_rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      rd_n          = vecs[i].rd_n;
      wr_n          = vecs[i].wr_n;
      data_in       = vecs[i].din;
      rx_push_valid = vecs[i].pv;
      rx_push_data  = vecs[i].pd;
      tx_pop_ready  = vecs[i].pr;
      @(negedge clk_i);
      check($sformatf("v%0d_rxf_n", i), {31'd0, rxf_n}, {31'd0, vecs[i].rxf_n});
      check($sformatf("v%0d_txe_n", i), {31'd0, txe_n}, {31'd0, vecs[i].txe_n});
      check($sformatf("v%0d_data_out", i), {24'd0, data_out}, {24'd0, vecs[i].dout});
      check($sformatf("v%0d_data_oe", i), {31'd0, data_oe}, {31'd0, vecs[i].oe});
      check($sformatf("v%0d_rx_level", i), {27'd0, rx_level}, {27'd0, vecs[i].rxl});
      check($sformatf("v%0d_tx_level", i), {27'd0, tx_level}, {27'd0, vecs[i].txl});
      check($sformatf("v%0d_push_ready", i), {31'd0, rx_push_ready}, {31'd0, vecs[i].prdy});
      check($sformatf("v%0d_pop_valid", i), {31'd0, tx_pop_valid}, {31'd0, vecs[i].tval});
      check($sformatf("v%0d_pop_data", i), {24'd0, tx_pop_data}, {24'd0, vecs[i].tdata});
      check($sformatf("v%0d_errs", i), {30'd0, rd_err, wr_err}, 32'd0);
      $display("vec %0d: rd_n=%0b wr_n=%0b rxf_n=%0b txe_n=%0b data_out=0x%02h rx_level=%0d tx_level=%0d",
               i, rd_n, wr_n, rxf_n, txe_n, data_out, rx_level, tx_level);
    end

    // Drain the 0x3C written by the table.
    tx_pop_ready = 1'b1;
    @(negedge clk_i);
    tx_pop_ready = 1'b0;
    check("drain3c_tx_level", {27'd0, tx_level}, 32'd0);
    check("drain3c_pop_valid", {31'd0, tx_pop_valid}, 32'd0);
    $display("local pop: tx_level=%0d", tx_level);

    // Fill RX with 0x00..0x0F, then try a 17th push.
    for (int i = 0; i < 16; i++) begin
      rx_push_valid = 1'b1;
      rx_push_data  = 8'(i);
      @(negedge clk_i);
    end
    check("fill_push_ready", {31'd0, rx_push_ready}, 32'd0);
    check("fill_rx_level", {27'd0, rx_level}, 32'd16);
    rx_push_data = 8'hEE;
    @(negedge clk_i);
    rx_push_valid = 1'b0;
    check("push17_rx_level", {27'd0, rx_level}, 32'd16);
    $display("local fill: rx_level=%0d push_ready=%0b", rx_level, rx_push_ready);

    for (int i = 0; i < 16; i++) begin
      host_read(8'(i));
    end
    repeat (8) @(negedge clk_i);
    check("drain_rxf_n", {31'd0, rxf_n}, 32'd1);
    check("drain_rx_level", {27'd0, rx_level}, 32'd0);
    check("drain_rd_err", {31'd0, rd_err}, 32'd0);

    // Read strobe with nothing to read.
    rd_n = 1'b0;
    repeat (3) @(negedge clk_i);
    rd_n = 1'b1;
    repeat (4) @(negedge clk_i);
    check("empty_rd_err", {31'd0, rd_err}, 32'd1);
    check("empty_data_out", {24'd0, data_out}, 32'd0);
    check("empty_rx_level", {27'd0, rx_level}, 32'd0);
    check("empty_rxf_n", {31'd0, rxf_n}, 32'd1);
    $display("empty read: rd_err=%0b rx_level=%0d", rd_err, rx_level);

    // Sixteen host writes fill TX; the 17th is dropped.
    for (int i = 0; i < 16; i++) begin
      host_write(8'h40 + 8'(i), 1'b1);
    end
    repeat (8) @(negedge clk_i);
    check("txfull_txe_n", {31'd0, txe_n}, 32'd1);
    check("txfull_tx_level", {27'd0, tx_level}, 32'd16);
    check("txfull_wr_err", {31'd0, wr_err}, 32'd0);
    host_write(8'hEE, 1'b0);
    repeat (6) @(negedge clk_i);
    check("wr17_wr_err", {31'd0, wr_err}, 32'd1);
    check("wr17_tx_level", {27'd0, tx_level}, 32'd16);
    check("wr17_txe_n", {31'd0, txe_n}, 32'd1);

    tx_pop_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("txpop_valid", {31'd0, tx_pop_valid}, 32'd1);
      check("txpop_data", {24'd0, tx_pop_data}, {24'd0, 8'h40 + 8'(i)});
      $display("local pop: tx_pop_data=0x%02h expected 0x%02h", tx_pop_data, 8'h40 + 8'(i));
      @(negedge clk_i);
    end
    tx_pop_ready = 1'b0;
    check("txpop_end_level", {27'd0, tx_level}, 32'd0);
    check("txpop_end_valid", {31'd0, tx_pop_valid}, 32'd0);

    // Reset in the middle of a host read with three bytes queued.
    for (int i = 0; i < 3; i++) begin
      rx_push_valid = 1'b1;
      rx_push_data  = 8'h11 * 8'(i + 1);
      @(negedge clk_i);
    end
    rx_push_valid = 1'b0;
    wait_rxf_low("mid_rxf_timeout");
    rd_n = 1'b0;
    repeat (2) @(negedge clk_i);
    check("mid_rx_level", {27'd0, rx_level}, 32'd3);
    sync_rst = 1'b1;
    @(negedge clk_i);
    check("midrst_rxf_n", {31'd0, rxf_n}, 32'd1);
    check("midrst_txe_n", {31'd0, txe_n}, 32'd1);
    check("midrst_rx_level", {27'd0, rx_level}, 32'd0);
    check("midrst_tx_level", {27'd0, tx_level}, 32'd0);
    check("midrst_errs", {30'd0, rd_err, wr_err}, 32'd0);
    check("midrst_data_out", {24'd0, data_out}, 32'd0);
    $display("mid-read reset: rxf_n=%0b txe_n=%0b rx_level=%0d", rxf_n, txe_n, rx_level);
    rd_n = 1'b1;
    sync_rst = 1'b0;
    wait_txe_low("postrst_txe_low");
    check("postrst_rx_level", {27'd0, rx_level}, 32'd0);
    check("postrst_rxf_n", {31'd0, rxf_n}, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/ft245_dev_emu.md
Name: ft245_dev_emu

Overview:
- Synthesizable device-side model of the FT245-style asynchronous byte FIFO interface: the FTDI-chip end of the bus, answering a host engine that drives rd_n/wr_n.
- Drives rxf_n/txe_n. Presents RX bytes on a read strobe and captures TX bytes on a write strobe.
- Holds two internal FIFOs with local valid/ready ports: an RX FIFO the fabric fills for the host, and a TX FIFO the fabric drains after host writes.
- Used for on-FPGA loopback and in benches that need a cycle-honest FTDI responder.

Parameters:
- DEPTH_LOG2, 4, log2 of each internal FIFO depth (16 entries).
- PRECHARGE, 2, cycles rxf_n/txe_n stay high after a strobe returns high; legal range 1..15.

Ports:
- clk_i  in  1  single clock.
- sync_rst  in  1  synchronous, active-high reset.
- rd_n  in  1  host read strobe, active low, asynchronous to clk_i.
- wr_n  in  1  host write strobe, active low, asynchronous.
- data_in  in  8  host-driven bus value.
- rxf_n  out  1  low = RX byte available.
- txe_n  out  1  low = TX space available.
- data_out  out  8  RX FIFO head byte.
- data_oe  out  1  bus drive enable.
- rx_push_valid / rx_push_data[7:0] / rx_push_ready  in/in/out  local RX fill port.
- tx_pop_valid / tx_pop_data[7:0] / tx_pop_ready  out/out/in  local TX drain port.
- rx_level / tx_level  out  DEPTH_LOG2+1  FIFO occupancy.
- rd_err / wr_err  out  1  sticky protocol-violation flags.

Behaviour:
- Reset: all state returns to idle; both FIFOs flush. Reset values:
  - rxf_n=1, txe_n=1, data_out=0.
  - rx_push_ready=0, tx_pop_valid=0, levels=0, rd_err=0, wr_err=0.
  - Strobe sync flops reset to 1.
  - Reset mid-strobe abandons the transfer with no push/pop.
- Synchronisation:
  - rd_n and wr_n each pass a 2-flop sync (rd_s, wr_s).
  - Edges are detected against a third registered copy.
  - data_in is sampled unsynchronised, only at the wr_s falling-edge cycle.
- data_oe = ~rd_n, combinational from the raw pin, modelling the chip's tri-state buffer.
- data_out is registered and always tracks the RX FIFO head; it is stable before rxf_n falls.
- RX FSM: R_EMPTY -> R_READY -> R_STROBE -> R_PRECHG -> R_EMPTY/R_READY.
  - R_EMPTY: rxf_n=1; go R_READY when rx_level>0.
  - R_READY: rxf_n=0; on rd_s fall, rxf_n=1 from the next cycle, go R_STROBE.
  - R_STROBE: rxf_n=1; on rd_s rise, pop one entry (data_out shows next head 1 cycle later), go R_PRECHG.
  - R_PRECHG: rxf_n=1 for PRECHARGE cycles, then go by level.
- TX FSM: T_FULL -> T_READY -> T_STROBE -> T_PRECHG.
  - T_READY whenever tx_level < depth; txe_n=0.
  - On wr_s fall: push data_in into the TX FIFO, txe_n=1 next cycle, go T_STROBE.
  - T_STROBE: wait for wr_s rise, then T_PRECHG (PRECHARGE cycles, txe_n=1).
  - T_PRECHG exits to T_FULL when full, else T_READY.
- Local ports:
  - rx_push_ready = not full; transfer on valid&ready.
  - tx_pop_valid = not empty; tx_pop_data = head; transfer on valid&ready.
  - Simultaneous local and host access to the same FIFO in one cycle is legal; level changes net 0.
- Errors:
  - rd_s fall outside R_READY: set rd_err; no pop, no state change.
  - wr_s fall outside T_READY: set wr_err; byte dropped.
  - Both flags clear only on reset.
- Read and write FSMs are independent; concurrent strobes are served.
- Pointers wrap modulo depth; levels saturate at depth (full) and 0 (empty), never wrap.

Test Plan:
- Reset, then push 0xA5 locally:
  - rxf_n falls within 2 cycles of the push and data_out=0xA5.
  - rd_n low 3 cycles: rxf_n rises 3 cycles after rd_n falls.
  - After rd_n high: rx_level=0, and rxf_n stays 1 for at least PRECHARGE cycles.
- Host writes 0x3C with wr_n low 4 cycles and data held:
  - tx_pop_valid=1, tx_pop_data=0x3C.
  - txe_n high during the strobe and PRECHARGE, then low again.
- Fill the RX FIFO with 16 bytes 0x00..0x0F:
  - rx_push_ready=0 and a 17th push is refused.
  - 16 host reads return 0x00..0x0F in order; rxf_n ends 1.
- Host writes 16 bytes with tx_pop_ready=0:
  - txe_n stays 1 after the 16th.
  - A 17th wr_n strobe sets wr_err=1 and tx_level stays 16.
- rd_n pulse with the RX FIFO empty: rd_err=1, data_out=0, and no level change.
- Assert sync_rst mid-read (rd_n low, rx_level=3):
  - Next cycle rxf_n=1, txe_n=1, levels=0, errors=0.
  - txe_n falls after release.
